garage_door_sequencer: RTL and testbench

Request sequencer for the automatic garage door controller. It collects open/close requests from the wall button, the remote receiver and an internal auto-close timer, and arbitrates between them by fixed priority. It issues single-cycle `Activate` pulses to the door controller only when the door rests at a limit, and monitors motor run time for faults. It sits between the user-input front end and the door controller, and observes the controller's `UP_M`/`DN_M` and the limit switches.

---
 rtl/garage_pkg.sv | 26 ++
 rtl/garage_door_sequencer_req_edge_arb.sv | 52 +++++
 rtl/garage_door_sequencer.sv | 157 +++++++++++++++
 tb/tb_garage_door_sequencer.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/garage_pkg.sv
// Shared types for the garage door request sequencer: FSM states, grant source
// codes and a counter-width helper.
package garage_pkg;

    typedef enum logic [2:0] {
        ST_SYNC,
        ST_CLOSED,
        ST_OPEN,
        ST_OPENING,
        ST_CLOSING,
        ST_FAULT
    } door_state_t;

    typedef enum logic [1:0] {
        SRC_NONE   = 2'b00,
        SRC_WALL   = 2'b01,
        SRC_REMOTE = 2'b10,
        SRC_AUTO   = 2'b11
    } grant_src_t;

    // A zero-valued parameter still needs a one-bit counter to stay legal.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/garage_door_sequencer_req_edge_arb.sv
// Rising-edge detection for the wall and remote request levels, followed by a
// fixed-priority pick (wall > remote > auto). Lock suppresses every source.
module req_edge_arb
    import garage_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       wall_req,
    input  logic       remote_req,
    input  logic       auto_req,
    input  logic       lock,
    output logic [2:0] req_onehot,
    output grant_src_t req_src
);

    logic wall_q;
    logic remote_q;
    logic wall_edge;
    logic remote_edge;
    logic auto_ok;

    // The previous level is tracked every cycle, so an edge seen while locked is consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wall_q   <= 1'b0;
            remote_q <= 1'b0;
        end else begin
            wall_q   <= wall_req;
            remote_q <= remote_req;
        end
    end

    assign wall_edge   = wall_req & ~wall_q & ~lock;
    assign remote_edge = remote_req & ~remote_q & ~lock;
    assign auto_ok     = auto_req & ~lock;

    always_comb begin
        req_onehot = 3'b000;
        req_src    = SRC_NONE;
        if (wall_edge) begin
            req_onehot = 3'b001;
            req_src    = SRC_WALL;
        end else if (remote_edge) begin
            req_onehot = 3'b010;
            req_src    = SRC_REMOTE;
        end else if (auto_ok) begin
            req_onehot = 3'b100;
            req_src    = SRC_AUTO;
        end
    end

endmodule

// File: rtl/garage_door_sequencer.sv
// Garage door request sequencer: arbitrates user and auto-close requests, pulses
// Activate only while the door rests at a limit, and faults on over-long runs.
module garage_door_sequencer
    import garage_pkg::*;
#(
    parameter int AUTO_CLOSE_CYC  = 1000,
    parameter int RUN_TIMEOUT_CYC = 500
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Wall_Req,
    input  logic       Remote_Req,
    input  logic       Lock,
    input  logic       Beam_Blocked,
    input  logic       UP_Max,
    input  logic       DN_Max,
    input  logic       UP_M,
    input  logic       DN_M,
    output logic       Activate,
    output logic [1:0] Grant_Src,
    output logic       Door_Open,
    output logic       Busy,
    output logic       Obstruct,
    output logic       Fault
);

    localparam int AC_W = cnt_width(AUTO_CLOSE_CYC);
    localparam int RC_W = cnt_width(RUN_TIMEOUT_CYC);
    localparam logic [AC_W-1:0] AC_MAX  = AC_W'(AUTO_CLOSE_CYC);
    localparam logic [AC_W-1:0] AC_FIRE = AC_W'((AUTO_CLOSE_CYC > 0) ? AUTO_CLOSE_CYC - 1 : 0);
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RUN_TIMEOUT_CYC - 1);

    door_state_t     state;
    door_state_t     state_nxt;
    logic [AC_W-1:0] auto_cnt;
    logic [AC_W-1:0] auto_cnt_nxt;
    logic [RC_W-1:0] run_cnt;
    logic [RC_W-1:0] run_cnt_nxt;
    logic            activate_nxt;
    grant_src_t      src_nxt;
    logic            obstruct_nxt;
    logic            auto_req;
    logic [2:0]      req_onehot;
    grant_src_t      req_src;
    logic            req_valid;
    logic            motor_unused;

    // Decisions are made purely from the limit switches; motor status is informational.
    assign motor_unused = UP_M | DN_M;

    assign auto_req = (AUTO_CLOSE_CYC != 0) && (state == ST_OPEN)
                      && (auto_cnt == AC_FIRE) && !Beam_Blocked;

    req_edge_arb u_arb (
        .clk        (CLK),
        .rst        (RST),
        .wall_req   (Wall_Req),
        .remote_req (Remote_Req),
        .auto_req   (auto_req),
        .lock       (Lock),
        .req_onehot (req_onehot),
        .req_src    (req_src)
    );

    assign req_valid = |req_onehot;

    always_comb begin
        state_nxt    = state;
        activate_nxt = 1'b0;
        src_nxt      = grant_src_t'(Grant_Src);
        obstruct_nxt = Obstruct | ((state == ST_CLOSING) & Beam_Blocked);
        auto_cnt_nxt = auto_cnt;
        run_cnt_nxt  = run_cnt;
        if (UP_Max && DN_Max) begin
            state_nxt = ST_FAULT;
        end else begin
            case (state)
                ST_SYNC: begin
                    if (DN_Max) begin
                        state_nxt = ST_CLOSED;
                    end else if (UP_Max) begin
                        state_nxt    = ST_OPEN;
                        auto_cnt_nxt = '0;
                    end
                end
                ST_CLOSED: begin
                    if (req_valid) begin
                        state_nxt    = ST_OPENING;
                        activate_nxt = 1'b1;
                        src_nxt      = req_src;
                        obstruct_nxt = 1'b0;
                        run_cnt_nxt  = '0;
                    end
                end
                ST_OPEN: begin
                    // A blocked beam drops the close request and restarts the auto-close wait.
                    if (req_valid && !Beam_Blocked) begin
                        state_nxt    = ST_CLOSING;
                        activate_nxt = 1'b1;
                        src_nxt      = req_src;
                        run_cnt_nxt  = '0;
                    end else if (Beam_Blocked) begin
                        auto_cnt_nxt = '0;
                    end else if (!Lock && auto_cnt != AC_MAX) begin
                        auto_cnt_nxt = auto_cnt + 1'b1;
                    end
                end
                ST_OPENING: begin
                    if (UP_Max) begin
                        state_nxt    = ST_OPEN;
                        auto_cnt_nxt = '0;
                    end else if (run_cnt >= RC_LAST) begin
                        state_nxt = ST_FAULT;
                    end else begin
                        run_cnt_nxt = run_cnt + 1'b1;
                    end
                end
                ST_CLOSING: begin
                    if (DN_Max) begin
                        state_nxt = ST_CLOSED;
                    end else if (run_cnt >= RC_LAST) begin
                        state_nxt = ST_FAULT;
                    end else begin
                        run_cnt_nxt = run_cnt + 1'b1;
                    end
                end
                ST_FAULT: ;
                default: state_nxt = ST_FAULT;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= ST_SYNC;
            auto_cnt  <= '0;
            run_cnt   <= '0;
            Activate  <= 1'b0;
            Grant_Src <= SRC_NONE;
            Door_Open <= 1'b0;
            Busy      <= 1'b0;
            Obstruct  <= 1'b0;
            Fault     <= 1'b0;
        end else begin
            state     <= state_nxt;
            auto_cnt  <= auto_cnt_nxt;
            run_cnt   <= run_cnt_nxt;
            Activate  <= activate_nxt;
            Grant_Src <= src_nxt;
            Door_Open <= (state_nxt == ST_OPEN);
            Busy      <= (state_nxt == ST_OPENING) || (state_nxt == ST_CLOSING);
            Obstruct  <= obstruct_nxt;
            Fault     <= (state_nxt == ST_FAULT);
        end
    end

endmodule

// File: tb/tb_garage_door_sequencer.sv
// Scoreboard bench for garage_door_sequencer: a behavioural door model predicts
// every Activate pulse and status flag; directed scenarios plus randomized traffic.
module tb_garage_door_sequencer;

    localparam int AC   = 8;
    localparam int RT   = 6;
    localparam int PMAX = 4;

    logic       CLK = 1'b0;
    logic       RST, Wall_Req, Remote_Req, Lock, Beam_Blocked;
    logic       UP_Max, DN_Max, UP_M, DN_M;
    logic       Activate, Door_Open, Busy, Obstruct, Fault;
    logic [1:0] Grant_Src;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int pos      = 0;

    typedef enum {M_SYNC, M_CLOSED, M_OPEN, M_OPENING, M_CLOSING, M_FAULT} mode_t;
    typedef struct {
        int         cyc;
        logic [1:0] src;
    } act_t;

    act_t       exp_q[$];
    act_t       mon_e;
    mode_t      mode       = M_SYNC;
    int         open_clear = 0;
    int         run_time   = 0;
    bit         prev_w     = 1'b0;
    bit         prev_r     = 1'b0;
    bit         m_obstruct = 1'b0;
    logic [1:0] m_src      = 2'b00;

    always #5 CLK = ~CLK;

    garage_door_sequencer #(.AUTO_CLOSE_CYC(AC), .RUN_TIMEOUT_CYC(RT)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .Wall_Req     (Wall_Req),
        .Remote_Req   (Remote_Req),
        .Lock         (Lock),
        .Beam_Blocked (Beam_Blocked),
        .UP_Max       (UP_Max),
        .DN_Max       (DN_Max),
        .UP_M         (UP_M),
        .DN_M         (DN_M),
        .Activate     (Activate),
        .Grant_Src    (Grant_Src),
        .Door_Open    (Door_Open),
        .Busy         (Busy),
        .Obstruct     (Obstruct),
        .Fault        (Fault)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic issue(input logic [1:0] src);
        exp_q.push_back('{cyc, src});
        m_src = src;
    endtask

    task automatic model_reset();
        mode = M_SYNC; open_clear = 0; run_time = 0;
        prev_w = 1'b0; prev_r = 1'b0; m_obstruct = 1'b0; m_src = 2'b00;
        exp_q.delete();
    endtask

    // Door behaviour as described for users: edges, priorities, timers in plain integers.
    task automatic model_step();
        bit         w_edge, r_edge, a_fire;
        logic [1:0] sel;
        w_edge = Wall_Req && !prev_w && !Lock;
        r_edge = Remote_Req && !prev_r && !Lock;
        a_fire = (AC > 0) && (mode == M_OPEN) && (open_clear == AC - 1) && !Beam_Blocked && !Lock;
        prev_w = Wall_Req;
        prev_r = Remote_Req;
        sel = w_edge ? 2'b01 : (r_edge ? 2'b10 : (a_fire ? 2'b11 : 2'b00));
        if (mode == M_CLOSING && Beam_Blocked) m_obstruct = 1'b1;
        if (UP_Max && DN_Max) begin
            mode = M_FAULT;
            return;
        end
        case (mode)
            M_SYNC: begin
                if (DN_Max) mode = M_CLOSED;
                else if (UP_Max) begin mode = M_OPEN; open_clear = 0; end
            end
            M_CLOSED: begin
                if (sel != 2'b00) begin
                    issue(sel); m_obstruct = 1'b0; mode = M_OPENING; run_time = 0;
                end
            end
            M_OPEN: begin
                if (sel != 2'b00 && !Beam_Blocked) begin
                    issue(sel); mode = M_CLOSING; run_time = 0;
                end else if (Beam_Blocked) open_clear = 0;
                else if (!Lock && open_clear < AC) open_clear++;
            end
            M_OPENING, M_CLOSING: begin
                if (mode == M_OPENING && UP_Max) begin
                    mode = M_OPEN; open_clear = 0;
                end else if (mode == M_CLOSING && DN_Max) begin
                    mode = M_CLOSED;
                end else begin
                    run_time++;
                    if (run_time >= RT) mode = M_FAULT;
                end
            end
            default: ;
        endcase
    endtask

    always @(posedge CLK) begin
        cyc++;
        if (RST) model_reset();
        else model_step();
    end

    always @(negedge CLK) begin
        if (!RST) begin
            checkOutput("door_open", Door_Open, mode == M_OPEN);
            checkOutput("busy", Busy, (mode == M_OPENING) || (mode == M_CLOSING));
            checkOutput("fault", Fault, mode == M_FAULT);
            checkOutput("obstruct", Obstruct, m_obstruct);
            checkOutput("grant_src", Grant_Src, m_src);
            if (Activate === 1'b1) begin
                if (exp_q.size() == 0) checkOutput("activate_unexpected", Activate, 1'b0);
                else begin
                    mon_e = exp_q.pop_front();
                    checkOutput("activate_cycle", cyc, mon_e.cyc);
                end
            end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                checkOutput("activate_missing", Activate, 1'b1);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic countActivate(input int limit, output int k);
        k = -1;
        for (int i = 1; i <= limit; i++) begin
            step(1);
            if (Activate === 1'b1) begin k = i; return; end
        end
    endtask

    // Random user traffic plus a crude door plant that travels between the limits.
    task automatic applyStimulus();
        if ((mode == M_FAULT && $urandom_range(0, 3) == 0) || $urandom_range(0, 599) == 0) begin
            RST = 1'b1;
            pos = ($urandom_range(0, 1) == 1) ? PMAX : 0;
        end else begin
            RST = 1'b0;
            if (mode == M_OPENING && pos < PMAX && $urandom_range(0, 9) < 8) pos++;
            else if (mode == M_CLOSING && pos > 0 && $urandom_range(0, 9) < 8) pos--;
        end
        UP_Max = (pos == PMAX);
        DN_Max = (pos == 0);
        if ($urandom_range(0, 399) == 0) begin UP_Max = 1'b1; DN_Max = 1'b1; end
        if ($urandom_range(0, 5) == 0) Wall_Req = ~Wall_Req;
        if ($urandom_range(0, 5) == 0) Remote_Req = ~Remote_Req;
        if ($urandom_range(0, 14) == 0) Lock = ~Lock;
        Beam_Blocked = ($urandom_range(0, 9) == 0);
        UP_M = (mode == M_OPENING);
        DN_M = (mode == M_CLOSING);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int k;
        RST = 1'b1; Wall_Req = 1'b0; Remote_Req = 1'b0; Lock = 1'b0; Beam_Blocked = 1'b0;
        UP_Max = 1'b0; DN_Max = 1'b1; UP_M = 1'b0; DN_M = 1'b0;
        step(2);
        RST = 1'b0;
        step(1);
        checkOutput("reset_activate", Activate, 1'b0);
        checkOutput("reset_busy", Busy, 1'b0);
        checkOutput("reset_open", Door_Open, 1'b0);
        checkOutput("reset_grant", Grant_Src, 2'b00);

        Wall_Req = 1'b1;
        step(1);
        checkOutput("wall_activate", Activate, 1'b1);
        checkOutput("wall_grant", Grant_Src, 2'b01);
        checkOutput("wall_busy", Busy, 1'b1);
        Wall_Req = 1'b0; DN_Max = 1'b0;
        step(1);
        checkOutput("activate_single", Activate, 1'b0);
        step(1);
        UP_Max = 1'b1;
        step(1);
        checkOutput("opened", Door_Open, 1'b1);
        checkOutput("opened_busy", Busy, 1'b0);

        Wall_Req = 1'b1; Remote_Req = 1'b1;
        step(1);
        checkOutput("both_activate", Activate, 1'b1);
        checkOutput("both_grant", Grant_Src, 2'b01);
        Wall_Req = 1'b0; Remote_Req = 1'b0; UP_Max = 1'b0;
        step(1);
        checkOutput("both_single", Activate, 1'b0);
        step(1);
        DN_Max = 1'b1;
        step(1);

        Remote_Req = 1'b1;
        step(1);
        checkOutput("remote_grant", Grant_Src, 2'b10);
        Remote_Req = 1'b0; DN_Max = 1'b0;
        step(1);
        UP_Max = 1'b1;
        step(1);
        countActivate(20, k);
        checkOutput("auto_close_delay", k, 8);
        checkOutput("auto_grant", Grant_Src, 2'b11);
        UP_Max = 1'b0;
        step(1);
        DN_Max = 1'b1;
        step(1);

        Wall_Req = 1'b1;
        step(1);
        Wall_Req = 1'b0; DN_Max = 1'b0;
        step(1);
        UP_Max = 1'b1;
        step(1);
        k = -1;
        for (int i = 1; i <= 30; i++) begin
            Beam_Blocked = (i == 5);
            step(1);
            if (Activate === 1'b1) begin k = i; break; end
        end
        Beam_Blocked = 1'b0;
        checkOutput("auto_close_beam_delay", k, 13);
        UP_Max = 1'b0;
        step(1);
        DN_Max = 1'b1;
        step(1);

        Lock = 1'b1; Remote_Req = 1'b1;
        step(1);
        checkOutput("lock_activate", Activate, 1'b0);
        step(2);
        checkOutput("lock_busy", Busy, 1'b0);
        Lock = 1'b0;
        step(2);
        checkOutput("unlock_activate", Activate, 1'b0);
        checkOutput("unlock_busy", Busy, 1'b0);
        Remote_Req = 1'b0;

        Wall_Req = 1'b1;
        step(1);
        checkOutput("timeout_start", Activate, 1'b1);
        Wall_Req = 1'b0; DN_Max = 1'b0;
        k = -1;
        for (int i = 1; i <= 12; i++) begin
            step(1);
            if (Fault === 1'b1) begin k = i; break; end
        end
        checkOutput("timeout_delay", k, 6);
        checkOutput("timeout_busy", Busy, 1'b0);
        Wall_Req = 1'b1; Remote_Req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1);
            checkOutput("fault_no_activate", Activate, 1'b0);
        end
        checkOutput("fault_sticky", Fault, 1'b1);
        Wall_Req = 1'b0; Remote_Req = 1'b0; DN_Max = 1'b1; RST = 1'b1;
        step(2);
        RST = 1'b0;
        step(1);
        checkOutput("fault_cleared", Fault, 1'b0);

        Wall_Req = 1'b1;
        step(1);
        Wall_Req = 1'b0; DN_Max = 1'b0;
        step(1);
        UP_Max = 1'b1;
        step(1);
        Wall_Req = 1'b1;
        step(1);
        Wall_Req = 1'b0; UP_Max = 1'b0; Beam_Blocked = 1'b1;
        step(1);
        Beam_Blocked = 1'b0;
        step(1);
        checkOutput("obstruct_set", Obstruct, 1'b1);
        DN_Max = 1'b1;
        step(1);
        checkOutput("obstruct_held", Obstruct, 1'b1);
        Wall_Req = 1'b1;
        step(1);
        checkOutput("reopen_activate", Activate, 1'b1);
        checkOutput("obstruct_cleared", Obstruct, 1'b0);
        Wall_Req = 1'b0; DN_Max = 1'b0;
        step(1);
        checkOutput("midrun_busy", Busy, 1'b1);
        #1;
        RST = 1'b1;
        #1;
        checkOutput("async_activate", Activate, 1'b0);
        checkOutput("async_busy", Busy, 1'b0);
        checkOutput("async_grant", Grant_Src, 2'b00);
        checkOutput("async_open", Door_Open, 1'b0);
        checkOutput("async_fault", Fault, 1'b0);
        DN_Max = 1'b1;
        step(2);
        RST = 1'b0;
        step(1);
        pos = 0;

        for (int i = 0; i < 4000; i++) begin
            applyStimulus();
            step(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
